// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX/MEM stage: control bundle, MEM/WB
// bundle, word geometry and the alignment helper.
package ex_mem_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned OFS_W      = $clog2(WORD_BYTES);

  // Opcode-independent control bits carried from execute.
  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
  } ctrl_t;

  // MEM/WB pipeline register payload.
  typedef struct packed {
    logic [XLEN-1:0]  readdata;
    logic [XLEN-1:0]  aluresult;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memtoreg;
    logic             misaligned;
  } memwb_t;

  // True when a byte address falls on a word boundary.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[OFS_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/ex_mem_stage_data_memory.sv
// Word-addressed data memory: single port, synchronous write, asynchronous read.
// Contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable for the current edge
//   addr  - word index
//   wdata - write data
//   rdata - combinational read data at addr
module data_memory #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata = mem[addr];

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, data memory access, branch resolution and MEM/WB
// pipeline register.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   stall, flush        - hazard-unit controls (flush overrides stall at EX/MEM)
//   aluresult..memtoreg - execute-stage results and MEM/WB control bits
//   pcsrc, branch_target- branch redirect to fetch (combinational from EX/MEM)
//   wb_*                - writeback operands to the register file
//   misaligned          - one-cycle flag for a misaligned load/store
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] aluresult,
  input  logic        zero,
  input  logic [31:0] addresult,
  input  logic [31:0] alureaddata2,
  input  logic [4:0]  rd_or_rt,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        regwrite,
  input  logic        memtoreg,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic [31:0] wb_readdata,
  output logic [31:0] wb_aluresult,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic        misaligned
);

  ctrl_t            in_ctrl;
  ctrl_t            em_ctrl;
  logic [XLEN-1:0]  em_aluresult;
  logic [XLEN-1:0]  em_addresult;
  logic [XLEN-1:0]  em_wdata;
  logic             em_zero;
  logic [REG_W-1:0] em_rd;

  memwb_t           wb_q;

  logic              aligned;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [XLEN-1:0]   mem_rdata;

  assign in_ctrl = ctrl_t'{branch, memread, memwrite, regwrite, memtoreg};

  // EX/MEM register: flush bubbles the control bits, stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_ctrl      <= '0;
      em_aluresult <= '0;
      em_addresult <= '0;
      em_wdata     <= '0;
      em_zero      <= 1'b0;
      em_rd        <= '0;
    end else if (flush) begin
      em_ctrl <= '0;
    end else if (!stall) begin
      em_ctrl      <= in_ctrl;
      em_aluresult <= aluresult;
      em_addresult <= addresult;
      em_wdata     <= alureaddata2;
      em_zero      <= zero;
      em_rd        <= rd_or_rt;
    end
  end

  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign aligned  = is_aligned(em_aluresult);
  assign mem_addr = em_aluresult[ADDR_W+OFS_W-1:OFS_W];
  // Gating with !stall keeps a held store from writing more than once.
  assign mem_we   = em_ctrl.memwrite & aligned & ~stall;

  data_memory #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (em_wdata),
    .rdata (mem_rdata)
  );

  // Branch resolution straight from the EX/MEM contents.
  assign pcsrc         = em_ctrl.branch & em_zero & ~stall;
  assign branch_target = em_addresult;

  // MEM/WB register: stall injects a bubble by dropping the enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (stall) begin
      wb_q.regwrite   <= 1'b0;
      wb_q.memtoreg   <= 1'b0;
      wb_q.misaligned <= 1'b0;
    end else begin
      wb_q.readdata   <= (em_ctrl.memread & aligned) ? mem_rdata : '0;
      wb_q.aluresult  <= em_aluresult;
      wb_q.rd         <= em_rd;
      wb_q.regwrite   <= em_ctrl.regwrite;
      wb_q.memtoreg   <= em_ctrl.memtoreg;
      wb_q.misaligned <= (em_ctrl.memread | em_ctrl.memwrite) & ~aligned;
    end
  end

  assign wb_readdata  = wb_q.readdata;
  assign wb_aluresult = wb_q.aluresult;
  assign wb_rd        = wb_q.rd;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign misaligned   = wb_q.misaligned;

endmodule
